// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch queue between the fetch PC and instruction memory.
// Keeps one memory request in flight and buffers fetched words until Decode consumes them.
module inst_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic [4:0]  occupancy,
  output logic [1:0]  dbgState
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} stateT;

  stateT          state;
  logic [31:0]    fetchPc;
  logic [31:0]    nextPc;
  logic [31:0]    redirectTgt;
  logic [PW-1:0]  rdPtr;
  logic [PW-1:0]  wrPtr;
  logic [4:0]     count;
  logic [4:0]     countNext;
  logic           push;
  logic           pop;
  logic [31:0]    dataMem [DEPTH];
  logic [31:0]    pcMem   [DEPTH];

  // Handshake: mem_req/mem_addr hold until the cycle mem_ready is seen high; the
  // head entry is consumed in any cycle with instr_valid=1, stall=0 and redirect=0.
  assign redirectTgt = {redirect_pc[31:2], 2'b00};
  assign nextPc      = fetchPc + 32'd4;
  assign push        = (state == REQ) && mem_ready && !redirect;
  assign pop         = (count != 5'd0) && !stall && !redirect;
  assign countNext   = redirect ? 5'd0 : (count + {4'b0, push} - {4'b0, pop});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_addr <= 32'h0;
      fetchPc  <= RESET_PC;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= 5'd0;
    end else begin
      count <= countNext;
      if (redirect) begin
        rdPtr   <= '0;
        wrPtr   <= '0;
        fetchPc <= redirectTgt;
      end else begin
        if (push) begin
          wrPtr   <= wrPtr + 1'b1;
          fetchPc <= nextPc;
        end
        if (pop) rdPtr <= rdPtr + 1'b1;
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            state    <= REQ;
            mem_addr <= redirectTgt;
          end else if (count < DEPTH_C) begin
            state    <= REQ;
            mem_addr <= fetchPc;
          end
        end
        REQ: begin
          if (redirect) begin
            // A redirect that coincides with completion can reissue at once;
            // otherwise the in-flight word must be drained and thrown away.
            if (mem_ready) mem_addr <= redirectTgt;
            else           state    <= DROP;
          end else if (mem_ready) begin
            if (countNext < DEPTH_C) mem_addr <= nextPc;
            else                     state    <= IDLE;
          end
        end
        DROP: begin
          if (mem_ready) begin
            state    <= REQ;
            mem_addr <= redirect ? redirectTgt : fetchPc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dataMem[wrPtr] <= mem_rdata;
      pcMem[wrPtr]   <= fetchPc;
    end
  end

  assign mem_req     = (state != IDLE);
  assign instr_valid = (count != 5'd0);
  assign instr       = instr_valid ? dataMem[rdPtr] : 32'h0;
  assign instr_pc    = instr_valid ? pcMem[rdPtr]   : 32'h0;
  assign pc_plus4    = instr_pc + 32'd4;
  assign occupancy   = count;
  assign dbgState    = state;

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset) push |-> (count < DEPTH_C));

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed bench for inst_prefetch_buffer (DEPTH=4, RESET_PC=0) with a
// zero-latency memory model returning {16'hC0DE, addr[15:0]}.
module tb_inst_prefetch_buffer;

  localparam logic [31:0] S_IDLE = 32'd0;
  localparam logic [31:0] S_REQ  = 32'd1;
  localparam logic [31:0] S_DROP = 32'd2;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [4:0]  occupancy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  inst_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .occupancy(occupancy), .dbgState(dbg_state)
  );

  assign mem_rdata = {16'hC0DE, mem_addr[15:0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_state", 32'(dbg_state), S_IDLE);

    reset = 1'b1;
    tick();
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", mem_addr, 32'h0);
    chk("first_state", 32'(dbg_state), S_REQ);

    // One wait cycle per request, no stall: each word is consumed the cycle after it lands.
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'b0;
      tick();
      chk("seq_hold_addr", mem_addr, 32'(4 * k));
      mem_ready = 1'b1;
      tick();
      chk("seq_occ", 32'(occupancy), 32'd1);
      chk("seq_pc", instr_pc, 32'(4 * k));
      chk("seq_pc4", pc_plus4, 32'(4 * k + 4));
      chk("seq_instr", instr, 32'hC0DE0000 + 32'(4 * k));
      chk("seq_next_addr", mem_addr, 32'(4 * k + 4));
    end

    // Redirect coinciding with completion: word at 0x10 dropped, reissue at 0.
    redirect = 1'b1; redirect_pc = 32'h0; mem_ready = 1'b1;
    tick();
    chk("rdr_rdy_occ", 32'(occupancy), 32'd0);
    chk("rdr_rdy_valid", 32'(instr_valid), 32'd0);
    chk("rdr_rdy_addr", mem_addr, 32'h0);
    chk("rdr_rdy_state", 32'(dbg_state), S_REQ);

    // Stall held with zero-wait memory: fill to DEPTH, then stop requesting.
    redirect = 1'b0; stall = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_occ", 32'(occupancy), 32'(i + 1));
      if (i < 3) chk("fill_addr", mem_addr, 32'(4 * (i + 1)));
      else       chk("fill_idle", 32'(mem_req), 32'd0);
    end
    tick();
    tick();
    chk("full_mem_req", 32'(mem_req), 32'd0);
    chk("full_state", 32'(dbg_state), S_IDLE);
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_addr_not_10", mem_addr, 32'h0C);
    chk("full_head", instr_pc, 32'h0);

    // Release from full, then a simultaneous push and pop.
    stall = 1'b0;
    tick();
    chk("pop1_occ", 32'(occupancy), 32'd3);
    chk("pop1_idle", 32'(mem_req), 32'd0);
    chk("pop1_head", instr_pc, 32'h4);
    stall = 1'b1;
    tick();
    chk("req10_addr", mem_addr, 32'h10);
    chk("req10_req", 32'(mem_req), 32'd1);
    chk("req10_occ", 32'(occupancy), 32'd3);
    stall = 1'b0;
    tick();
    chk("pushpop_occ", 32'(occupancy), 32'd3);
    chk("pushpop_head", instr_pc, 32'h8);
    chk("pushpop_addr", mem_addr, 32'h14);
    stall = 1'b1;
    tick();
    chk("refull_occ", 32'(occupancy), 32'd4);
    chk("refull_idle", 32'(mem_req), 32'd0);
    stall = 1'b0; mem_ready = 1'b0;
    tick();
    chk("order_c", instr_pc, 32'h0C);
    chk("order_c_instr", instr, 32'hC0DE000C);
    tick();
    chk("order_10", instr_pc, 32'h10);
    chk("order_req18", mem_addr, 32'h18);
    tick();
    chk("order_14", instr_pc, 32'h14);
    chk("order_14_instr", instr, 32'hC0DE0014);

    // Redirect while waiting: go to DROP, hold address, flush the head.
    redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    chk("drop_state", 32'(dbg_state), S_DROP);
    chk("drop_addr_held", mem_addr, 32'h18);
    chk("drop_req", 32'(mem_req), 32'd1);
    chk("drop_valid", 32'(instr_valid), 32'd0);
    chk("drop_instr_nop", instr, 32'h0);
    chk("drop_instr_pc", instr_pc, 32'h0);
    redirect = 1'b0; mem_ready = 1'b1; stall = 1'b1;
    tick();
    chk("drop_done_state", 32'(dbg_state), S_REQ);
    chk("drop_done_addr", mem_addr, 32'h0);
    chk("drop_done_occ", 32'(occupancy), 32'd0);
    tick();
    tick();
    tick();
    chk("three_occ", 32'(occupancy), 32'd3);
    chk("three_addr", mem_addr, 32'h0C);
    chk("three_head", instr_pc, 32'h0);

    // Three queued, request to 0x0C pending, redirect to 0x40.
    mem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("r40_occ", 32'(occupancy), 32'd0);
    chk("r40_state", 32'(dbg_state), S_DROP);
    chk("r40_addr_held", mem_addr, 32'h0C);
    redirect = 1'b0; mem_ready = 1'b1;
    tick();
    chk("r40_next_addr", mem_addr, 32'h40);
    chk("r40_discard_occ", 32'(occupancy), 32'd0);
    chk("r40_discard_valid", 32'(instr_valid), 32'd0);

    // Back-to-back redirects: DROP retargets while still waiting.
    mem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    chk("rr1_state", 32'(dbg_state), S_DROP);
    redirect_pc = 32'h200;
    tick();
    chk("rr2_state", 32'(dbg_state), S_DROP);
    chk("rr2_addr_held", mem_addr, 32'h40);
    redirect = 1'b0; mem_ready = 1'b1;
    tick();
    chk("rr_final_addr", mem_addr, 32'h200);

    // Reset in the middle of a request to 0x08 with mem_ready pulsing.
    redirect = 1'b1; redirect_pc = 32'h08; mem_ready = 1'b1;
    tick();
    chk("pre_rst_addr", mem_addr, 32'h08);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    redirect = 1'b0; mem_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_addr", mem_addr, 32'h0);
    chk("async_rst_state", 32'(dbg_state), S_IDLE);
    mem_ready = 1'b1;
    tick();
    tick();
    chk("in_rst_occ", 32'(occupancy), 32'd0);
    chk("in_rst_req", 32'(mem_req), 32'd0);
    reset = 1'b1; mem_ready = 1'b0;
    tick();
    chk("post_rst_addr", mem_addr, 32'h0);
    chk("post_rst_req", 32'(mem_req), 32'd1);
    chk("post_rst_occ", 32'(occupancy), 32'd0);

    // Refill, then redirect from IDLE to an unaligned target.
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("refill_occ", 32'(occupancy), 32'd4);
    chk("refill_idle", 32'(dbg_state), S_IDLE);
    mem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    chk("idle_rdr_addr", mem_addr, 32'h40);
    chk("idle_rdr_state", 32'(dbg_state), S_REQ);
    chk("idle_rdr_occ", 32'(occupancy), 32'd0);

    // Fetch PC wrap at the top of the address space.
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    chk("wrap_drop", 32'(dbg_state), S_DROP);
    redirect = 1'b0; mem_ready = 1'b1;
    tick();
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_occ", 32'(occupancy), 32'd1);
    chk("wrap_head", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    chk("wrap_instr", instr, 32'hC0DE_FFFC);
    chk("wrap_next_addr", mem_addr, 32'h0);
    mem_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
